i8088_bus_master: RTL and testbench



---
 rtl/i8088_bus_master.sv | 165 ++++++++++++++++
 tb/tb_i8088_bus_master.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/i8088_bus_master.sv
// i8088_bus_master: 8088-style bus initiator that turns single valid/ready
// requests into T1..T4 bus cycles, including wait states and the two-pulse
// interrupt-acknowledge sequence. All outputs are registered.
// Optional feature macro: BUS_TIMEOUT_EN (aborts a cycle after
// TIMEOUT_CYCLES consecutive wait states). Without it, the master waits forever.
module i8088_bus_master #(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_type,
  input  logic [19:0] req_address,
  input  logic [7:0]  req_wdata,
  input  logic        req_lock,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_timeout,
  output logic [19:0] cpu_address,
  output logic [7:0]  cpu_data_bus,
  output logic [2:0]  processor_status,
  output logic        processor_lock_n,
  input  logic        processor_ready,
  input  logic [7:0]  data_bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_T1, S_T2, S_T3, S_TW, S_T4, S_TI1, S_TI2
  } state_t;

  localparam logic [2:0] TYPE_INTA    = 3'b000;
  localparam logic [2:0] TYPE_IO_RD   = 3'b001;
  localparam logic [2:0] TYPE_IO_WR   = 3'b010;
  localparam logic [2:0] TYPE_HALT    = 3'b011;
  localparam logic [2:0] TYPE_CODE    = 3'b100;
  localparam logic [2:0] TYPE_MEM_RD  = 3'b101;
  localparam logic [2:0] TYPE_MEM_WR  = 3'b110;
  localparam logic [2:0] TYPE_ILLEGAL = 3'b111;
  localparam logic [2:0] STATUS_PASSIVE = 3'b111;

  // A timeout of zero wait states is meaningless; reject it at elaboration.
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t     state;
  logic [2:0] cyc_type;
  logic       inta_second;
  logic       is_read;
  logic       first_inta;
  logic       t4_abort;

  assign is_read    = (cyc_type == TYPE_INTA) || (cyc_type == TYPE_IO_RD) ||
                      (cyc_type == TYPE_CODE) || (cyc_type == TYPE_MEM_RD);
  assign first_inta = (cyc_type == TYPE_INTA) && !inta_second;

`ifdef BUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_count;
  // rsp_timeout is only high during a T4 that was reached by abort.
  assign t4_abort = rsp_timeout;
`else
  assign t4_abort    = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  // Bus cycle sequencer: state and every bus/response output move together.
  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= S_IDLE;
      cyc_type         <= TYPE_INTA;
      inta_second      <= 1'b0;
      req_ready        <= 1'b0;
      rsp_valid        <= 1'b0;
      rsp_rdata        <= 8'h00;
      cpu_address      <= 20'h00000;
      cpu_data_bus     <= 8'h00;
      processor_status <= STATUS_PASSIVE;
      processor_lock_n <= 1'b1;
`ifdef BUS_TIMEOUT_EN
      rsp_timeout      <= 1'b0;
      wait_count       <= '0;
`endif
    end else begin
      rsp_valid <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      rsp_timeout <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready && (req_type != TYPE_ILLEGAL)) begin
            state            <= S_T1;
            req_ready        <= 1'b0;
            cyc_type         <= req_type;
            inta_second      <= 1'b0;
            cpu_address      <= req_address;
            processor_status <= req_type;
            cpu_data_bus     <= ((req_type == TYPE_IO_WR) || (req_type == TYPE_MEM_WR)) ?
                                req_wdata : 8'h00;
            processor_lock_n <= (req_type == TYPE_INTA) ? 1'b1 : ~req_lock;
          end
        end
        S_T1: begin
          state <= S_T2;
          if (first_inta) processor_lock_n <= 1'b0;
        end
        S_T2: begin
          state <= S_T3;
          if ((cyc_type == TYPE_INTA) && inta_second) processor_lock_n <= 1'b1;
`ifdef BUS_TIMEOUT_EN
          wait_count <= '0;
`endif
        end
        S_T3, S_TW: begin
          if (processor_ready || (cyc_type == TYPE_HALT)) begin
            state            <= S_T4;
            processor_status <= STATUS_PASSIVE;
            rsp_valid        <= !first_inta;
            if (!is_read)
              rsp_rdata <= 8'h00;
            else if (!first_inta)
              rsp_rdata <= data_bus;
          end
`ifdef BUS_TIMEOUT_EN
          else if ((state == S_TW) && (wait_count == CNT_W'(TIMEOUT_CYCLES - 1))) begin
            state            <= S_T4;
            processor_status <= STATUS_PASSIVE;
            rsp_valid        <= 1'b1;
            rsp_timeout      <= 1'b1;
            rsp_rdata        <= 8'hFF;
          end
`endif
          else begin
            state <= S_TW;
`ifdef BUS_TIMEOUT_EN
            if (state == S_TW) wait_count <= wait_count + 1'b1;
`endif
          end
        end
        S_T4: begin
          if (first_inta && !t4_abort) begin
            state <= S_TI1;
          end else begin
            state            <= S_IDLE;
            req_ready        <= 1'b1;
            cpu_address      <= 20'h00000;
            cpu_data_bus     <= 8'h00;
            processor_lock_n <= 1'b1;
            processor_status <= STATUS_PASSIVE;
          end
        end
        S_TI1: state <= S_TI2;
        S_TI2: begin
          state            <= S_T1;
          inta_second      <= 1'b1;
          processor_status <= cyc_type;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i8088_bus_master.sv
// Directed testbench for i8088_bus_master. Cycle numbering follows the
// accept edge N: the first check after accept is cycle N+1.
module tb_i8088_bus_master;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_type = 3'b000;
  logic [19:0] req_address = 20'h0;
  logic [7:0]  req_wdata = 8'h0;
  logic        req_lock = 1'b0;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_timeout;
  logic [19:0] cpu_address;
  logic [7:0]  cpu_data_bus;
  logic [2:0]  processor_status;
  logic        processor_lock_n;
  logic        processor_ready = 1'b1;
  logic [7:0]  data_bus = 8'h00;

  int tests = 0;
  int fails = 0;

  i8088_bus_master #(.TIMEOUT_CYCLES(4)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type),
    .req_address(req_address), .req_wdata(req_wdata), .req_lock(req_lock),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
    .cpu_address(cpu_address), .cpu_data_bus(cpu_data_bus),
    .processor_status(processor_status), .processor_lock_n(processor_lock_n),
    .processor_ready(processor_ready), .data_bus(data_bus)
  );

  always #5 clock = ~clock;

  // Advance one cycle; sampling and driving happen 1 time unit after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present a request and wait (bounded) for the handshake; returns in cycle N+1.
  task automatic issue(input logic [2:0] t, input logic [19:0] a,
                       input logic [7:0] w, input logic l);
    int n = 0;
    req_type = t; req_address = a; req_wdata = w; req_lock = l; req_valid = 1'b1;
    while (!req_ready && n < 20) begin tick(); n++; end
    tests++;
    if (!req_ready) begin
      fails++;
      $display("[TB] FAIL accept_wait: req_ready got %b required 1 within 20 cycles", req_ready);
    end
    tick();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    tests++; if (req_ready !== 1'b0) begin fails++; $display("[TB] FAIL rst_req_ready: got %b required 0", req_ready); end
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("[TB] FAIL rst_rsp_valid: got %b required 0", rsp_valid); end
    tests++; if (rsp_rdata !== 8'h00) begin fails++; $display("[TB] FAIL rst_rsp_rdata: got %h required 00", rsp_rdata); end
    tests++; if (rsp_timeout !== 1'b0) begin fails++; $display("[TB] FAIL rst_rsp_timeout: got %b required 0", rsp_timeout); end
    tests++; if (cpu_address !== 20'h0) begin fails++; $display("[TB] FAIL rst_address: got %h required 00000", cpu_address); end
    tests++; if (cpu_data_bus !== 8'h00) begin fails++; $display("[TB] FAIL rst_data_bus: got %h required 00", cpu_data_bus); end
    tests++; if (processor_status !== 3'b111) begin fails++; $display("[TB] FAIL rst_status: got %b required 111", processor_status); end
    tests++; if (processor_lock_n !== 1'b1) begin fails++; $display("[TB] FAIL rst_lock_n: got %b required 1", processor_lock_n); end
    reset = 1'b0;
    tick();
    tests++; if (req_ready !== 1'b1) begin fails++; $display("[TB] FAIL rst_release_ready: got %b required 1", req_ready); end
  endtask

  task automatic test_mem_read();
    processor_ready = 1'b1; data_bus = 8'hEA;
    issue(3'b101, 20'hFFFF0, 8'h33, 1'b0);
    for (int c = 1; c <= 5; c++) begin
      tests++; if (processor_status !== ((c <= 3) ? 3'b101 : 3'b111)) begin fails++; $display("[TB] FAIL memrd_status N+%0d: got %b required %b", c, processor_status, (c <= 3) ? 3'b101 : 3'b111); end
      tests++; if (rsp_valid !== (c == 4)) begin fails++; $display("[TB] FAIL memrd_rsp_valid N+%0d: got %b required %b", c, rsp_valid, c == 4); end
      tests++; if (req_ready !== (c == 5)) begin fails++; $display("[TB] FAIL memrd_req_ready N+%0d: got %b required %b", c, req_ready, c == 5); end
      tests++; if (cpu_address !== ((c <= 4) ? 20'hFFFF0 : 20'h0)) begin fails++; $display("[TB] FAIL memrd_address N+%0d: got %h", c, cpu_address); end
      if (c == 4) begin
        tests++; if (rsp_rdata !== 8'hEA) begin fails++; $display("[TB] FAIL memrd_rdata: got %h required EA", rsp_rdata); end
        tests++; if (rsp_timeout !== 1'b0) begin fails++; $display("[TB] FAIL memrd_timeout: got %b required 0", rsp_timeout); end
      end
      if (c < 5) tick();
    end
  endtask

  task automatic test_inta();
    logic [2:0] exp_st;
    logic       exp_lk;
    processor_ready = 1'b1; data_bus = 8'h00;
    issue(3'b000, 20'h0ABCD, 8'h77, 1'b0);
    for (int c = 1; c <= 11; c++) begin
      if (c == 5) data_bus = 8'h08;
      exp_st = ((c <= 3) || (c >= 7 && c <= 9)) ? 3'b000 : 3'b111;
      exp_lk = !((c >= 2) && (c <= 8));
      tests++; if (processor_status !== exp_st) begin fails++; $display("[TB] FAIL inta_status N+%0d: got %b required %b", c, processor_status, exp_st); end
      tests++; if (processor_lock_n !== exp_lk) begin fails++; $display("[TB] FAIL inta_lock_n N+%0d: got %b required %b", c, processor_lock_n, exp_lk); end
      tests++; if (rsp_valid !== (c == 10)) begin fails++; $display("[TB] FAIL inta_rsp_valid N+%0d: got %b required %b", c, rsp_valid, c == 10); end
      tests++; if (cpu_address !== ((c <= 10) ? 20'h0ABCD : 20'h0)) begin fails++; $display("[TB] FAIL inta_address N+%0d: got %h", c, cpu_address); end
      if (c >= 4 && c <= 9) begin
        tests++; if (rsp_rdata !== 8'hEA) begin fails++; $display("[TB] FAIL inta_rdata_hold N+%0d: got %h required EA", c, rsp_rdata); end
      end
      if (c == 10) begin
        tests++; if (rsp_rdata !== 8'h08) begin fails++; $display("[TB] FAIL inta_vector: got %h required 08", rsp_rdata); end
      end
      if (c < 11) tick();
    end
  endtask

  task automatic test_locked_write();
    processor_ready = 1'b1;
    issue(3'b110, 20'h12345, 8'h5A, 1'b1);
    for (int c = 1; c <= 5; c++) begin
      tests++; if (processor_lock_n !== (c == 5)) begin fails++; $display("[TB] FAIL lockwr_lock_n N+%0d: got %b required %b", c, processor_lock_n, c == 5); end
      tests++; if (cpu_data_bus !== ((c <= 4) ? 8'h5A : 8'h00)) begin fails++; $display("[TB] FAIL lockwr_data N+%0d: got %h", c, cpu_data_bus); end
      tests++; if (processor_status !== ((c <= 3) ? 3'b110 : 3'b111)) begin fails++; $display("[TB] FAIL lockwr_status N+%0d: got %b", c, processor_status); end
      if (c == 4) begin
        tests++; if (rsp_valid !== 1'b1) begin fails++; $display("[TB] FAIL lockwr_rsp_valid: got %b required 1", rsp_valid); end
        tests++; if (rsp_rdata !== 8'h00) begin fails++; $display("[TB] FAIL lockwr_rdata: got %h required 00", rsp_rdata); end
      end
      if (c < 5) tick();
    end
  endtask

  task automatic test_io_write_waits();
    data_bus = 8'hC3;
    issue(3'b010, 20'h00061, 8'h4C, 1'b0);
    processor_ready = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (c == 6) processor_ready = 1'b1;
      tests++; if (processor_status !== ((c <= 6) ? 3'b010 : 3'b111)) begin fails++; $display("[TB] FAIL iowr_status N+%0d: got %b", c, processor_status); end
      tests++; if (cpu_data_bus !== ((c <= 7) ? 8'h4C : 8'h00)) begin fails++; $display("[TB] FAIL iowr_data N+%0d: got %h", c, cpu_data_bus); end
      tests++; if (rsp_valid !== (c == 7)) begin fails++; $display("[TB] FAIL iowr_rsp_valid N+%0d: got %b required %b", c, rsp_valid, c == 7); end
      tests++; if (processor_lock_n !== 1'b1) begin fails++; $display("[TB] FAIL iowr_lock_n N+%0d: got %b required 1", c, processor_lock_n); end
      if (c == 7) begin
        tests++; if (rsp_rdata !== 8'h00) begin fails++; $display("[TB] FAIL iowr_rdata: got %h required 00", rsp_rdata); end
      end
      if (c < 8) tick();
    end
  endtask

  task automatic test_halt();
    processor_ready = 1'b0; data_bus = 8'h99;
    issue(3'b011, 20'h00100, 8'h00, 1'b0);
    for (int c = 1; c <= 5; c++) begin
      tests++; if (processor_status !== ((c <= 3) ? 3'b011 : 3'b111)) begin fails++; $display("[TB] FAIL halt_status N+%0d: got %b", c, processor_status); end
      tests++; if (rsp_valid !== (c == 4)) begin fails++; $display("[TB] FAIL halt_rsp_valid N+%0d: got %b required %b", c, rsp_valid, c == 4); end
      if (c == 4) begin
        tests++; if (rsp_rdata !== 8'h00) begin fails++; $display("[TB] FAIL halt_rdata: got %h required 00", rsp_rdata); end
      end
      if (c < 5) tick();
    end
    processor_ready = 1'b1;
  endtask

  task automatic test_illegal();
    req_type = 3'b111; req_address = 20'hABCDE; req_valid = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      tests++; if (req_ready !== 1'b1) begin fails++; $display("[TB] FAIL illegal_ready cyc %0d: got %b required 1", c, req_ready); end
      tests++; if (processor_status !== 3'b111) begin fails++; $display("[TB] FAIL illegal_status cyc %0d: got %b required 111", c, processor_status); end
      tests++; if (cpu_address !== 20'h0) begin fails++; $display("[TB] FAIL illegal_address cyc %0d: got %h required 00000", c, cpu_address); end
      tests++; if (rsp_valid !== 1'b0) begin fails++; $display("[TB] FAIL illegal_rsp_valid cyc %0d: got %b required 0", c, rsp_valid); end
    end
    req_valid = 1'b0;
  endtask

  task automatic test_reset_mid_cycle();
    processor_ready = 1'b0;
    issue(3'b001, 20'h003F8, 8'h00, 1'b1);
    tick(); tick(); tick();
    tests++; if (processor_status !== 3'b001) begin fails++; $display("[TB] FAIL midrst_tw_status: got %b required 001", processor_status); end
    reset = 1'b1;
    tick();
    tests++; if (processor_status !== 3'b111) begin fails++; $display("[TB] FAIL midrst_status: got %b required 111", processor_status); end
    tests++; if (processor_lock_n !== 1'b1) begin fails++; $display("[TB] FAIL midrst_lock_n: got %b required 1", processor_lock_n); end
    tests++; if (cpu_address !== 20'h0) begin fails++; $display("[TB] FAIL midrst_address: got %h required 00000", cpu_address); end
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("[TB] FAIL midrst_rsp_valid: got %b required 0", rsp_valid); end
    tests++; if (req_ready !== 1'b0) begin fails++; $display("[TB] FAIL midrst_req_ready: got %b required 0", req_ready); end
    reset = 1'b0; processor_ready = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      tests++; if (rsp_valid !== 1'b0) begin fails++; $display("[TB] FAIL midrst_no_rsp cyc %0d: got %b required 0", c, rsp_valid); end
      tests++; if (req_ready !== 1'b1) begin fails++; $display("[TB] FAIL midrst_ready cyc %0d: got %b required 1", c, req_ready); end
    end
  endtask

`ifdef BUS_TIMEOUT_EN
  task automatic test_timeout();
    processor_ready = 1'b0;
    issue(3'b101, 20'h00400, 8'h00, 1'b0);
    for (int c = 1; c <= 9; c++) begin
      tests++; if (rsp_valid !== (c == 8)) begin fails++; $display("[TB] FAIL tmo_rsp_valid N+%0d: got %b required %b", c, rsp_valid, c == 8); end
      tests++; if (processor_status !== ((c <= 7) ? 3'b101 : 3'b111)) begin fails++; $display("[TB] FAIL tmo_status N+%0d: got %b", c, processor_status); end
      tests++; if (rsp_timeout !== (c == 8)) begin fails++; $display("[TB] FAIL tmo_flag N+%0d: got %b required %b", c, rsp_timeout, c == 8); end
      if (c == 8) begin
        tests++; if (rsp_rdata !== 8'hFF) begin fails++; $display("[TB] FAIL tmo_rdata: got %h required FF", rsp_rdata); end
      end
      if (c < 9) tick();
    end
    tests++; if (req_ready !== 1'b1) begin fails++; $display("[TB] FAIL tmo_req_ready: got %b required 1", req_ready); end
    processor_ready = 1'b1;
  endtask
`endif

  initial begin
    #1;
    test_reset();
    test_mem_read();
    test_inta();
    test_locked_write();
    test_io_write_waits();
    test_halt();
    test_illegal();
    test_reset_mid_cycle();
`ifdef BUS_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Safety net so a stuck run still ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
